mmio_switch_input: RTL and testbench
====================================

// Module: mmio_switch_input
// PURPOSE
//  Memory-mapped FPGA->CPU input port for board switches and buttons. It synchronises and debounces SW/BTN.
//  It latches button presses as sticky event flags and exposes the results as read registers in the dmem address window.
//  Sits beside RAM on the processor data bus; the top level selects q_io over RAM q_dmem when io_hit=1.
// PARAMETERS
//  BASE_ADDR       12'hF00  word address of register 0 (4-word window, BASE_ADDR[1:0] must be 0)
//  NUM_SW          16       switch inputs
//  NUM_BTN         5        button inputs
//  DEBOUNCE_CYCLES 50000    clocks per debounce tick (1 ms at 50 MHz)
//  STABLE_TICKS    4        consecutive disagreeing ticks before a debounced bit flips
// PORTS
//  clock   in   1        processor clock; all state on rising edge
//  reset   in   1        asynchronous, active-high; clears all state
//  addr    in   12       dmem word address (address_dmem[11:0])
//  wren    in   1        dmem write enable
//  data    in   32       dmem write data
//  SW      in   NUM_SW   raw switch levels, asynchronous
//  BTN     in   NUM_BTN  raw button levels, asynchronous, 1 = pressed
//  q_io    out  32       read data, registered
//  io_hit  out  1        registered: previous-cycle addr was in window
//  irq     out  1        registered: |BTN_EVENT
// BEHAVIOUR
//  Reset: sync flops, debounced state, tick/stability counters, BTN_EVENT, EVT_CNT, q_io, io_hit, irq all 0.
//   Reset assertion mid-bounce discards all progress.
//  Sync: 2-flop synchroniser per input bit; the raw-to-sync delay is 2 clocks.
//  Tick: prescaler counts 0..DEBOUNCE_CYCLES-1 and wraps. tick=1 in the cycle where count==DEBOUNCE_CYCLES-1.
//  Debounce, per bit, evaluated only on tick:
//   sync==stable -> cnt<=0
//   sync!=stable, cnt<STABLE_TICKS-1 -> cnt++
//   sync!=stable, cnt==STABLE_TICKS-1 -> stable<=sync, cnt<=0
//   A glitch lasting fewer than STABLE_TICKS ticks never changes stable.
//  Press event: the debounced BTN bit goes 0->1 -> the matching BTN_EVENT bit is set the next clock.
//   Debounced release sets no event.
//  Register map (offset = addr-BASE_ADDR):
//   0 SW_STATE   RO   {zeros, stable SW}
//   1 BTN_STATE  RO   {zeros, stable BTN}
//   2 BTN_EVENT  W1C  {zeros, sticky flags}; write clears bits where data=1
//   3 EVT_CNT    RW0  {24'b0, 8-bit count}; any write clears it
//  EVT_CNT adds the popcount of rising edges each cycle and saturates at 255.
//   Clear and increment in the same cycle -> count = that cycle's increment.
//  Simultaneous set and W1C clear of the same BTN_EVENT bit -> the bit stays 1 (set wins).
//  Read: every clock, q_io <= the register selected by addr if in window, else 32'b0; io_hit <= in-window.
//   Latency is 1 clock, matching RAM.
//   A read and a write to the same register in the same cycle return the pre-write value.
//  Writes with addr outside the window, or to offsets 0 and 1, are ignored. Writes never affect RAM decoding here.
//  irq <= |BTN_EVENT (next-state value), registered.
// TESTING (DEBOUNCE_CYCLES=4, STABLE_TICKS=4, BASE_ADDR=12'hF00)
//  T1 reset: assert reset mid-cycle with state nonzero -> q_io, io_hit, irq = 0 immediately, before any clock edge.
//  T2 debounce: SW=16'hA5A5 held -> addr F00 reads 0 until flip.
//   After <=2+4*4+4 clocks it reads 32'h0000A5A5.
//   Then toggle SW[0] for 3 ticks only -> value unchanged.
//  T3 event/W1C: press BTN[2] -> F01=32'h4, F02=32'h4, irq=1, F03=1.
//   Then write 32'h4 to F02 -> F02=0, irq=0 next clock; F03 still 1.
//  T4 collision: W1C of bit2 in the same cycle its set occurs -> F02 bit2=1, irq=1.
//  T5 saturation: 260 debounced presses -> F03=255; write any value to F03 -> 0.
//  T6 decode/latency: addr=F00 at edge n -> q_io valid and io_hit=1 after edge n.
//   Then addr=12'h000 -> io_hit=0, q_io=0.
//   Then wren to 12'h004 -> no register changes.

Source files
------------

// File: rtl/mmio_switch_input.sv
// ---------------------------------------------------------------------------
// mmio_switch_input
//
// Memory-mapped input port that brings board switches and buttons onto the
// processor data bus. Each raw input is passed through a two-flop
// synchroniser and then debounced: a shared prescaler produces a periodic
// tick, and a bit's debounced value flips only after it has disagreed with
// the synchronised input on STABLE_TICKS consecutive ticks. A debounced
// button press sets a sticky event flag and bumps a saturating event counter.
//
// Register window (word offsets from BASE_ADDR):
//   0 SW_STATE   RO   debounced switches, zero-extended
//   1 BTN_STATE  RO   debounced buttons, zero-extended
//   2 BTN_EVENT  W1C  sticky press flags; writing 1 clears a flag
//   3 EVT_CNT    RW0  8-bit saturating press count; any write clears it
//
// Ports:
//   clock   processor clock, all state on the rising edge
//   reset   asynchronous active-high reset, clears all state
//   addr    dmem word address
//   wren    dmem write enable
//   data    dmem write data
//   SW      raw switch levels (asynchronous)
//   BTN     raw button levels (asynchronous, 1 = pressed)
//   q_io    registered read data, 1-clock latency like the RAM
//   io_hit  registered: address of the previous cycle fell in the window
//   irq     registered OR of all sticky event flags
// ---------------------------------------------------------------------------
module mmio_switch_input #(
    parameter logic [11:0] BASE_ADDR       = 12'hF00,
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 5,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          STABLE_TICKS    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [11:0]        addr,
    input  logic               wren,
    input  logic [31:0]        data,
    input  logic [NUM_SW-1:0]  SW,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [31:0]        q_io,
    output logic               io_hit,
    output logic               irq
);

    // Switches occupy the low bits of the combined vector, buttons the top.
    localparam int NB = NUM_SW + NUM_BTN;
    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

    logic [NB-1:0]          sync1_q, sync1_d;
    logic [NB-1:0]          sync2_q, sync2_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [NB-1:0]          stable_q, stable_d;
    logic [NB-1:0][CW-1:0]  dbc_cnt_q, dbc_cnt_d;
    logic [NUM_BTN-1:0]     btn_dly_q, btn_dly_d;
    logic [NUM_BTN-1:0]     event_q, event_d;
    logic [7:0]             evt_cnt_q, evt_cnt_d;
    logic [31:0]            q_io_q, q_io_d;
    logic                   io_hit_q, io_hit_d;
    logic                   irq_q, irq_d;

    logic                   tick;
    logic [NUM_BTN-1:0]     btn_stable;
    logic [NUM_BTN-1:0]     rise;
    logic                   in_window;
    logic [1:0]             offset;
    logic                   wr_evt;
    logic                   wr_cnt;
    logic [NUM_BTN-1:0]     clr_mask;
    logic [8:0]             evt_sum;

    // Only the low NUM_BTN data bits are ever consumed by a register.
    logic unused_data;
    assign unused_data = ^data;

    always_comb begin
        // Synchroniser chain
        sync1_d = {BTN, SW};
        sync2_d = sync1_q;

        // Debounce prescaler: tick is high in the last count of each period
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + PW'(1);

        // Per-bit debounce; the stability counter only moves on a tick, and
        // any agreeing tick throws away the accumulated disagreement.
        stable_d  = stable_q;
        dbc_cnt_d = dbc_cnt_q;
        if (tick) begin
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    dbc_cnt_d[i] = '0;
                end else if (dbc_cnt_q[i] == CNT_MAX) begin
                    stable_d[i]  = sync2_q[i];
                    dbc_cnt_d[i] = '0;
                end else begin
                    dbc_cnt_d[i] = dbc_cnt_q[i] + CW'(1);
                end
            end
        end

        // Press detection on the debounced buttons (releases are ignored)
        btn_stable = stable_q[NB-1:NUM_SW];
        btn_dly_d  = btn_stable;
        rise       = btn_stable & ~btn_dly_q;

        // Address decode
        in_window = (addr[11:2] == BASE_ADDR[11:2]);
        offset    = addr[1:0];
        wr_evt    = wren && in_window && (offset == 2'd2);
        wr_cnt    = wren && in_window && (offset == 2'd3);

        // Set is OR-ed in after the clear so a coincident press survives
        clr_mask = wr_evt ? data[NUM_BTN-1:0] : '0;
        event_d  = (event_q & ~clr_mask) | rise;

        // A clearing write replaces the old count, but this cycle's presses
        // still land on top of it.
        evt_sum = wr_cnt ? 9'd0 : {1'b0, evt_cnt_q};
        for (int i = 0; i < NUM_BTN; i++) begin
            evt_sum = evt_sum + 9'(rise[i]);
        end
        evt_cnt_d = (evt_sum > 9'd255) ? 8'hFF : evt_sum[7:0];

        // Read path uses current register contents, so a same-cycle write is
        // not visible until the following read.
        q_io_d = 32'd0;
        if (in_window) begin
            case (offset)
                2'd0:    q_io_d = 32'(stable_q[NUM_SW-1:0]);
                2'd1:    q_io_d = 32'(btn_stable);
                2'd2:    q_io_d = 32'(event_q);
                default: q_io_d = {24'd0, evt_cnt_q};
            endcase
        end
        io_hit_d = in_window;
        irq_d    = |event_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pre_q     <= '0;
            stable_q  <= '0;
            dbc_cnt_q <= '0;
            btn_dly_q <= '0;
            event_q   <= '0;
            evt_cnt_q <= '0;
            q_io_q    <= '0;
            io_hit_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pre_q     <= pre_d;
            stable_q  <= stable_d;
            dbc_cnt_q <= dbc_cnt_d;
            btn_dly_q <= btn_dly_d;
            event_q   <= event_d;
            evt_cnt_q <= evt_cnt_d;
            q_io_q    <= q_io_d;
            io_hit_q  <= io_hit_d;
            irq_q     <= irq_d;
        end
    end

    assign q_io   = q_io_q;
    assign io_hit = io_hit_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_switch_input.sv
module tb_mmio_switch_input;

    logic        clock;
    logic        reset;
    logic [11:0] addr;
    logic        wren;
    logic [31:0] data;
    logic [15:0] SW;
    logic [4:0]  BTN;
    logic [31:0] q_io;
    logic        io_hit;
    logic        irq;

    int total;
    int bad;

    mmio_switch_input #(
        .BASE_ADDR       (12'hF00),
        .NUM_SW          (16),
        .NUM_BTN         (5),
        .DEBOUNCE_CYCLES (4),
        .STABLE_TICKS    (4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .addr   (addr),
        .wren   (wren),
        .data   (data),
        .SW     (SW),
        .BTN    (BTN),
        .q_io   (q_io),
        .io_hit (io_hit),
        .irq    (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] v);
        addr = a;
        wren = 1'b0;
        step(1);
        v = q_io;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        addr = a;
        data = d;
        wren = 1'b1;
        step(1);
        wren = 1'b0;
        data = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        addr  = 12'h000;
        wren  = 1'b0;
        data  = 32'd0;
        SW    = 16'd0;
        BTN   = 5'd0;
        step(2);
        total++; if (q_io !== 32'd0) begin bad++; $display("FAIL reset_q_io got=%h want=%h", q_io, 32'd0); end
        total++; if (io_hit !== 1'b0) begin bad++; $display("FAIL reset_io_hit got=%b want=0", io_hit); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_debounce();
        logic [31:0] v;
        SW = 16'hA5A5;
        step(3);
        do_read(12'hF00, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL sw_before_flip got=%h want=%h", v, 32'd0); end
        step(24);
        do_read(12'hF00, v);
        total++; if (v !== 32'h0000A5A5) begin bad++; $display("FAIL sw_after_flip got=%h want=%h", v, 32'h0000A5A5); end
        // Glitch on SW[0] lasting exactly 3 ticks must not change anything
        SW = 16'hA5A4;
        step(11);
        do_read(12'hF00, v);
        total++; if (v !== 32'h0000A5A5) begin bad++; $display("FAIL sw_during_glitch got=%h want=%h", v, 32'h0000A5A5); end
        SW = 16'hA5A5;
        step(20);
        do_read(12'hF00, v);
        total++; if (v !== 32'h0000A5A5) begin bad++; $display("FAIL sw_after_glitch got=%h want=%h", v, 32'h0000A5A5); end
    endtask

    task automatic test_event_w1c();
        logic [31:0] v;
        BTN = 5'b00100;
        step(26);
        do_read(12'hF01, v);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL btn_state got=%h want=%h", v, 32'h4); end
        do_read(12'hF02, v);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL btn_event got=%h want=%h", v, 32'h4); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_after_press got=%b want=1", irq); end
        do_read(12'hF03, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL evt_cnt_one got=%h want=%h", v, 32'h1); end
        // W1C: the read in the write cycle sees the pre-write value
        do_write(12'hF02, 32'h4);
        total++; if (q_io !== 32'h4) begin bad++; $display("FAIL w1c_prewrite_read got=%h want=%h", q_io, 32'h4); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_w1c got=%b want=0", irq); end
        do_read(12'hF02, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_event_cleared got=%h want=%h", v, 32'h0); end
        do_read(12'hF03, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL evt_cnt_kept got=%h want=%h", v, 32'h1); end
        // Debounced release must not create an event
        BTN = 5'b00000;
        step(26);
        do_read(12'hF02, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL release_no_event got=%h want=%h", v, 32'h0); end
        do_read(12'hF01, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL btn_released got=%h want=%h", v, 32'h0); end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        int irq_seen;
        int evt_seen;
        irq_seen = 0;
        evt_seen = 0;
        // Hammer W1C on bit2 every cycle while the press debounces; set must
        // win in the rising-edge cycle, so the flag is visible exactly once.
        BTN  = 5'b00100;
        addr = 12'hF02;
        data = 32'h4;
        wren = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (irq === 1'b1) irq_seen++;
            if (q_io === 32'h4) evt_seen++;
        end
        wren = 1'b0;
        data = 32'd0;
        total++; if (irq_seen !== 1) begin bad++; $display("FAIL collision_irq got=%0d want=%0d", irq_seen, 1); end
        total++; if (evt_seen !== 1) begin bad++; $display("FAIL collision_flag got=%0d want=%0d", evt_seen, 1); end
        do_read(12'hF03, v);
        total++; if (v !== 32'h2) begin bad++; $display("FAIL collision_cnt got=%h want=%h", v, 32'h2); end
        BTN = 5'b00000;
        step(26);
    endtask

    task automatic test_multi_press();
        logic [31:0] v;
        do_write(12'hF03, 32'h0);
        BTN = 5'b10011;
        step(26);
        do_read(12'hF03, v);
        total++; if (v !== 32'h3) begin bad++; $display("FAIL multi_cnt got=%h want=%h", v, 32'h3); end
        do_read(12'hF02, v);
        total++; if (v !== 32'h13) begin bad++; $display("FAIL multi_event got=%h want=%h", v, 32'h13); end
        do_read(12'hF01, v);
        total++; if (v !== 32'h13) begin bad++; $display("FAIL multi_state got=%h want=%h", v, 32'h13); end
        BTN = 5'b00000;
        step(26);
        do_write(12'hF02, 32'h13);
        do_read(12'hF02, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL multi_cleared got=%h want=%h", v, 32'h0); end
    endtask

    task automatic test_saturation();
        logic [31:0] v;
        do_write(12'hF03, 32'h1234);
        do_read(12'hF03, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL cnt_clear got=%h want=%h", v, 32'h0); end
        for (int i = 0; i < 10; i++) begin
            BTN = 5'b00100; step(26);
            BTN = 5'b00000; step(26);
        end
        do_read(12'hF03, v);
        total++; if (v !== 32'd10) begin bad++; $display("FAIL cnt_ten got=%h want=%h", v, 32'd10); end
        for (int i = 0; i < 250; i++) begin
            BTN = 5'b00100; step(26);
            BTN = 5'b00000; step(26);
        end
        do_read(12'hF03, v);
        total++; if (v !== 32'd255) begin bad++; $display("FAIL cnt_saturated got=%h want=%h", v, 32'd255); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_saturation got=%b want=1", irq); end
        do_write(12'hF03, 32'h0);
        do_read(12'hF03, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL cnt_cleared got=%h want=%h", v, 32'h0); end
        BTN = 5'b00100; step(26);
        BTN = 5'b00000; step(26);
        do_read(12'hF03, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL cnt_after_clear got=%h want=%h", v, 32'h1); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        addr = 12'hF00;
        step(1);
        total++; if (io_hit !== 1'b1) begin bad++; $display("FAIL hit_in_window got=%b want=1", io_hit); end
        total++; if (q_io !== 32'h0000A5A5) begin bad++; $display("FAIL latency_read got=%h want=%h", q_io, 32'h0000A5A5); end
        addr = 12'h000;
        step(1);
        total++; if (io_hit !== 1'b0) begin bad++; $display("FAIL hit_outside got=%b want=0", io_hit); end
        total++; if (q_io !== 32'h0) begin bad++; $display("FAIL q_io_outside got=%h want=%h", q_io, 32'h0); end
        // Writes outside the window and to read-only offsets do nothing
        do_write(12'h004, 32'hFFFFFFFF);
        do_write(12'h006, 32'hFFFFFFFF);
        do_write(12'h007, 32'hFFFFFFFF);
        do_write(12'hF00, 32'h00000000);
        do_write(12'hF01, 32'hFFFFFFFF);
        do_read(12'hF02, v);
        total++; if (v !== 32'h4) begin bad++; $display("FAIL decode_event_kept got=%h want=%h", v, 32'h4); end
        do_read(12'hF03, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL decode_cnt_kept got=%h want=%h", v, 32'h1); end
        do_read(12'hF00, v);
        total++; if (v !== 32'h0000A5A5) begin bad++; $display("FAIL decode_sw_kept got=%h want=%h", v, 32'h0000A5A5); end
        do_read(12'hF01, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL decode_btn_kept got=%h want=%h", v, 32'h0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        addr = 12'hF00;
        step(1);
        total++; if (q_io !== 32'h0000A5A5) begin bad++; $display("FAIL pre_reset_q_io got=%h want=%h", q_io, 32'h0000A5A5); end
        // Assert reset between edges; outputs must drop without a clock edge
        #2;
        reset = 1'b1;
        #1;
        total++; if (q_io !== 32'h0) begin bad++; $display("FAIL async_reset_q_io got=%h want=%h", q_io, 32'h0); end
        total++; if (io_hit !== 1'b0) begin bad++; $display("FAIL async_reset_io_hit got=%b want=0", io_hit); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_reset_irq got=%b want=0", irq); end
        step(2);
        reset = 1'b0;
        do_read(12'hF00, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_sw got=%h want=%h", v, 32'h0); end
        do_read(12'hF02, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_event got=%h want=%h", v, 32'h0); end
        do_read(12'hF03, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_cnt got=%h want=%h", v, 32'h0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_debounce();
        test_event_w1c();
        test_collision();
        test_multi_press();
        test_saturation();
        test_decode();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
